// File: rtl/multi_lifo.sv
// multi_lifo: CHANNELS independent LIFO stacks that share one simple-dual-port
// memory of CHANNELS*2**AWIDTH words, addressed by {channel, pointer}.
//
// Ports:
//   clk_i, srst_i           clock, synchronous active-high reset
//   wrreq_i, wr_ch_i, data_i   push request, channel, data
//   rdreq_i, rd_ch_i           pop request, channel
//   q_o, q_valid_o             popped word (held), one-cycle valid pulse
//   empty_o, full_o            per-channel empty / full flags
//   almost_empty_o             per-channel usedw <= AE_LEVEL
//   almost_full_o              per-channel usedw >= AF_LEVEL
//   usedw_o                    packed per-channel counts, channel 0 in LSBs
//   ovf_o, udf_o               sticky push-to-full / pop-from-empty errors
module multi_lifo #(
    parameter int DWIDTH   = 8,
    parameter int AWIDTH   = 4,
    parameter int CHANNELS = 4,
    parameter int AF_LEVEL = 2**AWIDTH - 2,
    parameter int AE_LEVEL = 2,
    localparam int CWIDTH  = $clog2(CHANNELS)
) (
    input  logic                            clk_i,
    input  logic                            srst_i,
    input  logic                            wrreq_i,
    input  logic [CWIDTH-1:0]               wr_ch_i,
    input  logic [DWIDTH-1:0]               data_i,
    input  logic                            rdreq_i,
    input  logic [CWIDTH-1:0]               rd_ch_i,
    output logic [DWIDTH-1:0]               q_o,
    output logic                            q_valid_o,
    output logic [CHANNELS-1:0]             empty_o,
    output logic [CHANNELS-1:0]             full_o,
    output logic [CHANNELS-1:0]             almost_empty_o,
    output logic [CHANNELS-1:0]             almost_full_o,
    output logic [CHANNELS*(AWIDTH+1)-1:0]  usedw_o,
    output logic                            ovf_o,
    output logic                            udf_o
);

    localparam int MEM_WORDS = CHANNELS * (2**AWIDTH);
    localparam logic [AWIDTH:0] DEPTH_CNT = {1'b1, {AWIDTH{1'b0}}};
    localparam logic [AWIDTH:0] AF_CNT    = AF_LEVEL[AWIDTH:0];
    localparam logic [AWIDTH:0] AE_CNT    = AE_LEVEL[AWIDTH:0];

    logic [DWIDTH-1:0] mem_q [MEM_WORDS];

    logic [AWIDTH:0]   cnt_q [CHANNELS];
    logic [AWIDTH:0]   cnt_d [CHANNELS];

    logic [DWIDTH-1:0] q_q;
    logic              q_valid_q;
    logic [CHANNELS-1:0] empty_q, full_q, ae_q, af_q;
    logic              ovf_q, udf_q;

    logic                     wr_en, rd_en;
    logic [CWIDTH+AWIDTH-1:0] wr_addr, rd_addr;
    logic                     ovf_set, udf_set;
    logic [AWIDTH:0]          wr_cnt, rd_cnt, rd_top;
    logic                     same_ch;

    // Next-state decode for counts, memory strobes and error events.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        for (int c = 0; c < CHANNELS; c++) cnt_d[c] = cnt_q[c];
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_addr = '0;
        rd_addr = '0;
        ovf_set = 1'b0;
        udf_set = 1'b0;

        wr_cnt  = cnt_q[wr_ch_i];
        rd_cnt  = cnt_q[rd_ch_i];
        rd_top  = rd_cnt - 1'b1;
        same_ch = wrreq_i && rdreq_i && (wr_ch_i == rd_ch_i);

        if (same_ch && rd_cnt != '0) begin
            // Replace: read old top and overwrite it in one cycle; the memory
            // returns old data on the colliding address, count is unchanged.
            wr_en   = 1'b1;
            rd_en   = 1'b1;
            wr_addr = {wr_ch_i, rd_top[AWIDTH-1:0]};
            rd_addr = {rd_ch_i, rd_top[AWIDTH-1:0]};
        end else begin
            // Pop is judged against the pre-cycle count, so a same-channel
            // push+pop on an empty stack pushes and flags an underflow.
            if (rdreq_i) begin
                if (rd_cnt != '0) begin
                    rd_en            = 1'b1;
                    rd_addr          = {rd_ch_i, rd_top[AWIDTH-1:0]};
                    cnt_d[rd_ch_i]   = rd_top;
                end else begin
                    udf_set = 1'b1;
                end
            end
            if (wrreq_i) begin
                if (wr_cnt != DEPTH_CNT) begin
                    wr_en          = 1'b1;
                    wr_addr        = {wr_ch_i, wr_cnt[AWIDTH-1:0]};
                    cnt_d[wr_ch_i] = wr_cnt + 1'b1;
                end else begin
                    ovf_set = 1'b1;
                end
            end
        end
    end

    // Memory array and read port.
    // NOTE: the storage array has no reset; stale words are unreachable once
    // the counts are cleared, and leaving it unreset lets it map onto RAM.
    always_ff @(posedge clk_i) begin
        if (wr_en && !srst_i) mem_q[wr_addr] <= data_i;
    end

    // NOTE: all state below uses non-blocking assignment so the read of
    // mem_q sees the pre-edge value, which gives old-data read-during-write.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            q_q       <= '0;
            q_valid_q <= 1'b0;
        end else begin
            q_valid_q <= rd_en;
            if (rd_en) q_q <= mem_q[rd_addr];
        end
    end

    // Counts, registered flags and sticky errors.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            for (int c = 0; c < CHANNELS; c++) cnt_q[c] <= '0;
            empty_q <= '1;
            ae_q    <= '1;
            full_q  <= '0;
            af_q    <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                cnt_q[c]   <= cnt_d[c];
                empty_q[c] <= (cnt_d[c] == '0);
                full_q[c]  <= (cnt_d[c] == DEPTH_CNT);
                ae_q[c]    <= (cnt_d[c] <= AE_CNT);
                af_q[c]    <= (cnt_d[c] >= AF_CNT);
            end
            if (ovf_set) ovf_q <= 1'b1;
            if (udf_set) udf_q <= 1'b1;
        end
    end

    always_comb begin
        usedw_o = '0;
        for (int c = 0; c < CHANNELS; c++) usedw_o[c*(AWIDTH+1) +: AWIDTH+1] = cnt_q[c];
    end

    assign q_o            = q_q;
    assign q_valid_o      = q_valid_q;
    assign empty_o        = empty_q;
    assign full_o         = full_q;
    assign almost_empty_o = ae_q;
    assign almost_full_o  = af_q;
    assign ovf_o          = ovf_q;
    assign udf_o          = udf_q;

endmodule

// File: tb/tb_multi_lifo.sv
// Self-checking bench for multi_lifo: stimulus applies each operation to a
// queue-per-channel reference model and pushes the expected results into
// scoreboard queues; a monitor compares the DUT one edge later.
module tb_multi_lifo;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int CH    = 4;
    localparam int CW    = 2;
    localparam int DEPTH = 16;
    localparam int AF    = DEPTH - 2;
    localparam int AE    = 2;
    localparam int UW    = AW + 1;

    logic              clk = 1'b0;
    logic              srst_i = 1'b1;
    logic              wrreq_i = 1'b0;
    logic [CW-1:0]     wr_ch_i = '0;
    logic [DW-1:0]     data_i = '0;
    logic              rdreq_i = 1'b0;
    logic [CW-1:0]     rd_ch_i = '0;
    logic [DW-1:0]     q_o;
    logic              q_valid_o;
    logic [CH-1:0]     empty_o, full_o, almost_empty_o, almost_full_o;
    logic [CH*UW-1:0]  usedw_o;
    logic              ovf_o, udf_o;

    multi_lifo #(
        .DWIDTH(DW), .AWIDTH(AW), .CHANNELS(CH), .AF_LEVEL(AF), .AE_LEVEL(AE)
    ) dut (
        .clk_i(clk), .srst_i(srst_i),
        .wrreq_i(wrreq_i), .wr_ch_i(wr_ch_i), .data_i(data_i),
        .rdreq_i(rdreq_i), .rd_ch_i(rd_ch_i),
        .q_o(q_o), .q_valid_o(q_valid_o),
        .empty_o(empty_o), .full_o(full_o),
        .almost_empty_o(almost_empty_o), .almost_full_o(almost_full_o),
        .usedw_o(usedw_o), .ovf_o(ovf_o), .udf_o(udf_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          valid;
        logic [DW-1:0] q;
        logic [CH*UW-1:0] usedw;
        logic [CH-1:0] empty;
        logic [CH-1:0] full;
        logic [CH-1:0] ae;
        logic [CH-1:0] af;
        logic          ovf;
        logic          udf;
    } snap_t;

    // Reference model: one queue per channel, back of the queue is the top.
    logic [DW-1:0] stk [CH][$];
    logic [DW-1:0] m_last_q = '0;
    logic          m_ovf = 1'b0;
    logic          m_udf = 1'b0;

    logic [DW-1:0] exp_data [$];
    snap_t         exp_snap [$];

    int checks = 0;
    int fails  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus: drive at negedge, advance the model, queue results.
    task automatic drive(input logic rst, input logic wr, input int wch,
                         input logic [DW-1:0] d, input logic rd, input int rch);
        snap_t s;
        logic [DW-1:0] top;
        @(negedge clk);
        srst_i  = rst;
        wrreq_i = wr;
        wr_ch_i = CW'(wch);
        data_i  = d;
        rdreq_i = rd;
        rd_ch_i = CW'(rch);
        s = '0;
        if (rst) begin
            for (int c = 0; c < CH; c++) stk[c].delete();
            m_last_q = '0;
            m_ovf    = 1'b0;
            m_udf    = 1'b0;
        end else if (wr && rd && wch == rch && stk[wch].size() > 0) begin
            top = stk[wch].pop_back();
            stk[wch].push_back(d);
            s.valid  = 1'b1;
            m_last_q = top;
            exp_data.push_back(top);
        end else begin
            if (rd) begin
                if (stk[rch].size() > 0) begin
                    top = stk[rch].pop_back();
                    s.valid  = 1'b1;
                    m_last_q = top;
                    exp_data.push_back(top);
                end else begin
                    m_udf = 1'b1;
                end
            end
            if (wr) begin
                if (stk[wch].size() < DEPTH) stk[wch].push_back(d);
                else m_ovf = 1'b1;
            end
        end
        s.q   = m_last_q;
        s.ovf = m_ovf;
        s.udf = m_udf;
        for (int c = 0; c < CH; c++) begin
            s.usedw[c*UW +: UW] = UW'(stk[c].size());
            s.empty[c] = (stk[c].size() == 0);
            s.full[c]  = (stk[c].size() == DEPTH);
            s.ae[c]    = (stk[c].size() <= AE);
            s.af[c]    = (stk[c].size() >= AF);
        end
        exp_snap.push_back(s);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 0, '0, 1'b0, 0);
    endtask

    // Monitor: every edge that consumed a stimulus cycle is compared here.
    initial begin
        snap_t s;
        logic [DW-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_snap.size() > 0) begin
                s = exp_snap.pop_front();
                check("q_valid", 64'(q_valid_o), 64'(s.valid));
                if (q_valid_o) begin
                    if (exp_data.size() == 0) begin
                        check("unexpected_pop", 64'(q_valid_o), 64'(0));
                    end else begin
                        e = exp_data.pop_front();
                        check("q_data", 64'(q_o), 64'(e));
                    end
                end
                check("q_hold", 64'(q_o), 64'(s.q));
                check("usedw", 64'(usedw_o), 64'(s.usedw));
                check("empty", 64'(empty_o), 64'(s.empty));
                check("full", 64'(full_o), 64'(s.full));
                check("almost_empty", 64'(almost_empty_o), 64'(s.ae));
                check("almost_full", 64'(almost_full_o), 64'(s.af));
                check("ovf", 64'(ovf_o), 64'(s.ovf));
                check("udf", 64'(udf_o), 64'(s.udf));
            end
        end
    end

    initial begin
        int wch, rch, pw, pr;
        logic wr, rd;

        // Reset, with requests present that must be ignored.
        drive(1'b1, 1'b1, 1, 8'hAA, 1'b1, 1);
        drive(1'b1, 1'b0, 0, '0, 1'b0, 0);

        // Fill channel 1, overflow it, underflow channel 2, then drain LIFO order.
        for (int i = 0; i < DEPTH; i++) drive(1'b0, 1'b1, 1, DW'(8'h10 + i), 1'b0, 0);
        drive(1'b0, 1'b1, 1, 8'hEE, 1'b0, 0);
        drive(1'b0, 1'b0, 0, '0, 1'b1, 2);
        for (int i = 0; i < DEPTH; i++) drive(1'b0, 1'b0, 0, '0, 1'b1, 1);
        idle();
        drive(1'b1, 1'b0, 0, '0, 1'b0, 0);

        // Replace on channel 0 holding [A,B] with C.
        drive(1'b0, 1'b1, 0, 8'hA1, 1'b0, 0);
        drive(1'b0, 1'b1, 0, 8'hB2, 1'b0, 0);
        drive(1'b0, 1'b1, 0, 8'hC3, 1'b1, 0);
        drive(1'b0, 1'b0, 0, '0, 1'b1, 0);
        drive(1'b0, 1'b0, 0, '0, 1'b1, 0);

        // Push ch0 while popping ch3 holding [X].
        drive(1'b0, 1'b1, 3, 8'h5A, 1'b0, 0);
        drive(1'b0, 1'b1, 0, 8'h77, 1'b1, 3);
        // Same-channel push+pop on empty channel 2: push executes, udf set.
        drive(1'b0, 1'b1, 2, 8'h99, 1'b1, 2);
        // Replace on a full channel.
        for (int i = 0; i < DEPTH; i++) drive(1'b0, 1'b1, 1, DW'(8'h40 + i), 1'b0, 0);
        drive(1'b0, 1'b1, 1, 8'hF0, 1'b1, 1);
        drive(1'b0, 1'b0, 0, '0, 1'b1, 1);

        // Reset with words stored, then a pop that must underflow.
        drive(1'b1, 1'b0, 0, '0, 1'b1, 1);
        drive(1'b0, 1'b0, 0, '0, 1'b1, 0);
        drive(1'b1, 1'b0, 0, '0, 1'b0, 0);

        // Randomised traffic alternating fill-biased and drain-biased phases.
        for (int i = 0; i < 3000; i++) begin
            pw  = ((i / 250) % 2 == 0) ? 70 : 30;
            pr  = 100 - pw;
            wr  = ($urandom_range(99) < pw);
            rd  = ($urandom_range(99) < pr);
            if ($urandom_range(9) < 2) begin
                wr = 1'b0;
                rd = 1'b0;
            end
            wch = $urandom_range(CH-1);
            rch = ($urandom_range(9) == 0) ? wch : $urandom_range(CH-1);
            drive(1'b0, wr, wch, DW'($urandom), rd, rch);
        end

        idle();
        idle();
        @(posedge clk);
        #2;
        check("pending_pops", 64'(exp_data.size()), 64'(0));
        check("pending_snaps", 64'(exp_snap.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
